// File: rtl/sr_flipflop_bank.sv
// Bank of independent SR flip-flops with selectable S=R=1 policy and sticky conflict flags.
// Optional saturating conflict counter when SR_FLIPFLOP_BANK_CONFLICT_CNT_EN is defined.
module sr_flipflop_bank #(
   parameter int               WIDTH     = 8,
   parameter int               MODE      = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic             clr_conflict,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic [WIDTH-1:0] changed,
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
   output logic [CNT_W-1:0] conflict_cnt,
`endif
   output logic [WIDTH-1:0] conflict
);

   typedef enum logic [1:0] {
      POL_HOLD   = 2'd0,
      POL_SET    = 2'd1,
      POL_RESET  = 2'd2,
      POL_TOGGLE = 2'd3
   } policy_t;

   // Out-of-range MODE values fall back to hold.
   localparam policy_t POLICY =
      (MODE == 1) ? POL_SET    :
      (MODE == 2) ? POL_RESET  :
      (MODE == 3) ? POL_TOGGLE : POL_HOLD;

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] conflict_next;

   assign hit = en ? (S & R) : '0;

   always_comb begin
      q_next = Q;
      if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            unique case ({S[i], R[i]})
               2'b01: q_next[i] = 1'b0;
               2'b10: q_next[i] = 1'b1;
               2'b11: begin
                  unique case (POLICY)
                     POL_SET:    q_next[i] = 1'b1;
                     POL_RESET:  q_next[i] = 1'b0;
                     POL_TOGGLE: q_next[i] = ~Q[i];
                     default:    q_next[i] = Q[i];
                  endcase
               end
               default: q_next[i] = Q[i];
            endcase
         end
      end
   end

   // A new conflict wins over a simultaneous clear.
   assign conflict_next = (clr_conflict ? '0 : conflict) | hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Q        <= RESET_VAL;
         changed  <= '0;
         conflict <= '0;
      end else begin
         Q        <= q_next;
         changed  <= q_next ^ Q;
         conflict <= conflict_next;
      end
   end

   assign Qbar = ~Q;

`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic any_hit;

   assign any_hit = |hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (clr_conflict) begin
         conflict_cnt <= any_hit ? CNT_W'(1) : '0;
      end else if (any_hit && conflict_cnt != CNT_MAX) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Directed bench for sr_flipflop_bank: one instance per MODE plus a RESET_VAL=1010 instance.
// Counter checks are active when SR_FLIPFLOP_BANK_CONFLICT_CNT_EN is defined.
module tb_sr_flipflop_bank;

   localparam int W = 4;
   localparam int CW = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] S = '0;
   logic [W-1:0] R = '0;
   logic         clr_conflict = 1'b0;

   logic [W-1:0] q0, qb0, ch0, cf0;
   logic [W-1:0] q1, qb1, ch1, cf1;
   logic [W-1:0] q2, qb2, ch2, cf2;
   logic [W-1:0] q3, qb3, ch3, cf3;
   logic [W-1:0] q4, qb4, ch4, cf4;
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
   logic [CW-1:0] cn0, cn1, cn2, cn3, cn4;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
 `define CNT(n) .conflict_cnt(n),
`else
 `define CNT(n)
`endif

   sr_flipflop_bank #(.WIDTH(W), .MODE(0), .RESET_VAL(4'b0000), .CNT_W(CW)) u0 (
      .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_conflict(clr_conflict),
      .Q(q0), .Qbar(qb0), .changed(ch0), `CNT(cn0) .conflict(cf0));
   sr_flipflop_bank #(.WIDTH(W), .MODE(1), .RESET_VAL(4'b0000), .CNT_W(CW)) u1 (
      .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_conflict(clr_conflict),
      .Q(q1), .Qbar(qb1), .changed(ch1), `CNT(cn1) .conflict(cf1));
   sr_flipflop_bank #(.WIDTH(W), .MODE(2), .RESET_VAL(4'b0000), .CNT_W(CW)) u2 (
      .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_conflict(clr_conflict),
      .Q(q2), .Qbar(qb2), .changed(ch2), `CNT(cn2) .conflict(cf2));
   sr_flipflop_bank #(.WIDTH(W), .MODE(3), .RESET_VAL(4'b0000), .CNT_W(CW)) u3 (
      .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_conflict(clr_conflict),
      .Q(q3), .Qbar(qb3), .changed(ch3), `CNT(cn3) .conflict(cf3));
   sr_flipflop_bank #(.WIDTH(W), .MODE(0), .RESET_VAL(4'b1010), .CNT_W(CW)) u4 (
      .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_conflict(clr_conflict),
      .Q(q4), .Qbar(qb4), .changed(ch4), `CNT(cn4) .conflict(cf4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3 reset = 1'b1;
      #1;
      checks++;
      if (q0 !== 4'b0000) begin
         failures++;
         $display("FAIL reset_q0 got=%b want=0000", q0);
      end
      checks++;
      if (qb0 !== 4'b1111) begin
         failures++;
         $display("FAIL reset_qbar0 got=%b want=1111", qb0);
      end
      checks++;
      if (ch0 !== 4'b0000 || cf0 !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags0 changed=%b conflict=%b want=0000", ch0, cf0);
      end
      checks++;
      if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
         failures++;
         $display("FAIL reset_val4 q=%b qbar=%b want=1010/0101", q4, qb4);
      end
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
      checks++;
      if (cn0 !== 2'd0) begin
         failures++;
         $display("FAIL reset_cnt0 got=%0d want=0", cn0);
      end
`endif
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_set_reset();
      en = 1'b1;
      S = 4'b0101;
      R = 4'b1010;
      tick();
      checks++;
      if (q0 !== 4'b0101 || ch0 !== 4'b0101) begin
         failures++;
         $display("FAIL sr_load q=%b changed=%b want=0101/0101", q0, ch0);
      end
      checks++;
      if (qb0 !== 4'b1010) begin
         failures++;
         $display("FAIL sr_qbar got=%b want=1010", qb0);
      end
      checks++;
      if (q4 !== 4'b0101 || ch4 !== 4'b1111) begin
         failures++;
         $display("FAIL sr_load4 q=%b changed=%b want=0101/1111", q4, ch4);
      end
      S = 4'b0000;
      R = 4'b0000;
      tick();
      checks++;
      if (q0 !== 4'b0101 || ch0 !== 4'b0000) begin
         failures++;
         $display("FAIL sr_hold q=%b changed=%b want=0101/0000", q0, ch0);
      end
   endtask

   task automatic test_modes();
      S = 4'b1111;
      R = 4'b1111;
      tick();
      checks++;
      if (q0 !== 4'b0101) begin
         failures++;
         $display("FAIL mode0 got=%b want=0101", q0);
      end
      checks++;
      if (q1 !== 4'b1111) begin
         failures++;
         $display("FAIL mode1 got=%b want=1111", q1);
      end
      checks++;
      if (q2 !== 4'b0000) begin
         failures++;
         $display("FAIL mode2 got=%b want=0000", q2);
      end
      checks++;
      if (q3 !== 4'b1010 || ch3 !== 4'b1111) begin
         failures++;
         $display("FAIL mode3 q=%b changed=%b want=1010/1111", q3, ch3);
      end
      checks++;
      if (cf0 !== 4'b1111 || cf1 !== 4'b1111 || cf2 !== 4'b1111 || cf3 !== 4'b1111) begin
         failures++;
         $display("FAIL mode_conflict got=%b %b %b %b want=1111", cf0, cf1, cf2, cf3);
      end
      checks++;
      if (ch0 !== 4'b0000) begin
         failures++;
         $display("FAIL mode0_changed got=%b want=0000", ch0);
      end
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
      checks++;
      if (cn0 !== 2'd1) begin
         failures++;
         $display("FAIL mode_cnt got=%0d want=1", cn0);
      end
`endif
   endtask

   task automatic test_enable_off();
      en = 1'b0;
      S = 4'b0000;
      R = 4'b0000;
      clr_conflict = 1'b1;
      tick();
      clr_conflict = 1'b0;
      checks++;
      if (cf0 !== 4'b0000) begin
         failures++;
         $display("FAIL clr_conflict got=%b want=0000", cf0);
      end
      S = 4'b1111;
      R = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q0 !== 4'b0101 || q3 !== 4'b1010 || ch3 !== 4'b0000) begin
            failures++;
            $display("FAIL en_off_hold cyc=%0d q0=%b q3=%b ch3=%b", i, q0, q3, ch3);
         end
      end
      checks++;
      if (cf0 !== 4'b0000 || cf3 !== 4'b0000) begin
         failures++;
         $display("FAIL en_off_conflict got=%b %b want=0000", cf0, cf3);
      end
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
      checks++;
      if (cn0 !== 2'd0) begin
         failures++;
         $display("FAIL en_off_cnt got=%0d want=0", cn0);
      end
`endif
   endtask

   task automatic test_back_to_back_conflict();
      en = 1'b1;
      S = 4'b1111;
      R = 4'b1111;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (q0 !== 4'b0101 || q3 !== 4'b0101) begin
         failures++;
         $display("FAIL b2b_q q0=%b q3=%b want=0101/0101", q0, q3);
      end
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
      checks++;
      if (cn0 !== 2'd3) begin
         failures++;
         $display("FAIL cnt_saturate got=%0d want=3", cn0);
      end
`endif
      clr_conflict = 1'b1;
      tick();
      clr_conflict = 1'b0;
      checks++;
      if (cf0 !== 4'b1111) begin
         failures++;
         $display("FAIL clr_vs_set_flags got=%b want=1111", cf0);
      end
`ifdef SR_FLIPFLOP_BANK_CONFLICT_CNT_EN
      checks++;
      if (cn0 !== 2'd1) begin
         failures++;
         $display("FAIL clr_vs_inc_cnt got=%0d want=1", cn0);
      end
`endif
   endtask

   task automatic test_independent();
      S = 4'b0011;
      R = 4'b0100;
      tick();
      checks++;
      if (q0 !== 4'b0011 || ch0 !== 4'b0110) begin
         failures++;
         $display("FAIL independent q=%b changed=%b want=0011/0110", q0, ch0);
      end
   endtask

   task automatic test_reset_val();
      S = 4'b1111;
      R = 4'b0000;
      en = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
         failures++;
         $display("FAIL rv_assert q=%b qbar=%b want=1010/0101", q4, qb4);
      end
      tick();
      tick();
      checks++;
      if (q4 !== 4'b1010 || ch4 !== 4'b0000 || q0 !== 4'b0000) begin
         failures++;
         $display("FAIL rv_hold q4=%b ch4=%b q0=%b", q4, ch4, q0);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (q4 !== 4'b1010 || ch4 !== 4'b0000) begin
         failures++;
         $display("FAIL rv_release q=%b changed=%b want=1010/0000", q4, ch4);
      end
      tick();
      checks++;
      if (q4 !== 4'b1111 || ch4 !== 4'b0101) begin
         failures++;
         $display("FAIL rv_first_edge q=%b changed=%b want=1111/0101", q4, ch4);
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_set_reset();
      test_modes();
      test_enable_off();
      test_back_to_back_conflict();
      test_independent();
      test_reset_val();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_flipflop_bank.md
SR_FLIPFLOP_BANK -- requirements
Module: sr_flipflop_bank

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: the clock port is clk and the reset port is reset.
REQ-002 Parameters SHALL be as follows, one per line:
- WIDTH, 8: number of independent SR channels (1..32).
- MODE, 0: S=R=1 policy; 0 hold, 1 set-priority, 2 reset-priority, 3 toggle.
- RESET_VAL, all zeros: WIDTH-bit value loaded into Q on reset.
- CNT_W, 8: conflict counter width.
REQ-003 Ports SHALL be as follows, one per line:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous active-high reset.
- en, input, 1: channel update enable.
- S, input, WIDTH: per-channel set.
- R, input, WIDTH: per-channel reset.
- clr_conflict, input, 1: clears sticky conflict flags (and the counter, if compiled in).
- Q, output, WIDTH: registered state.
- Qbar, output, WIDTH: bitwise inverse of Q.
- changed, output, WIDTH: one-cycle pulse on channels whose Q changed at the last edge.
- conflict, output, WIDTH: sticky flag, set when a channel saw S=R=1 while en=1.
- conflict_cnt, output, CNT_W: saturating count of conflict cycles (present only with the macro).

Function
REQ-004 At each rising clk edge with en=1, each channel i SHALL update as follows:
- S=0, R=0: hold.
- S=0, R=1: Q[i]=0.
- S=1, R=0: Q[i]=1.
- S=1, R=1: per MODE (0 hold, 1 Q=1, 2 Q=0, 3 Q=~Q).
REQ-005 With en=0, Q SHALL hold, changed SHALL be 0, and no conflict SHALL be recorded, whatever the values on S and R.
REQ-006 Qbar SHALL always equal ~Q combinationally, including during reset.
REQ-007 changed[i] SHALL be 1 for exactly the one cycle after an edge at which Q[i] took a new value, and 0 otherwise; latency from S/R sampling to Q is one cycle.
REQ-008 conflict[i] SHALL set on the edge sampling en=1, S[i]=1, R[i]=1, and SHALL remain set until clr_conflict or reset.
REQ-009 When clr_conflict=1 and a new conflict occur on the same edge, the set SHALL win: the flag ends at 1.
REQ-010 Channels SHALL be fully independent; the only logic shared between channels is en, clr_conflict and the counter.
REQ-011 An invalid MODE value (greater than 3) SHALL behave as MODE 0.

Reset
REQ-012 While reset=1, regardless of clk, outputs SHALL be held as follows: Q=RESET_VAL, Qbar=~RESET_VAL, changed=0, conflict=0, conflict_cnt=0.
REQ-013 Reset asserted mid-operation SHALL discard any pending update; the first edge after release SHALL apply normal REQ-004 behaviour, and the return from reset itself SHALL NOT pulse changed.

Configuration
REQ-014 Macro SR_FLIPFLOP_BANK_CONFLICT_CNT_EN SHALL control the conflict counter, as follows:
- Defined: conflict_cnt exists and increments by 1 per edge on which any channel records a conflict. It saturates at 2^CNT_W-1 and clears on clr_conflict; a simultaneous clear and increment yields 1.
- Undefined: the conflict_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-015 The bench SHALL cover the following directed scenarios:
- WIDTH=4, MODE=0, reset pulse mid-cycle -> Q=0000 and Qbar=1111 immediately, without waiting for a clk edge.
- en=1, S=0101, R=1010 -> next cycle Q=0101, changed=0101; then S=R=0 -> Q holds and changed=0000.
- Q=0101, S=R=1111, en=1, run once per MODE -> Q as follows, with conflict=1111 each time:
  - MODE 0: 0101.
  - MODE 1: 1111.
  - MODE 2: 0000.
  - MODE 3: 1010.
- en=0 with S=R=1111 for 3 cycles -> Q unchanged, conflict=0000, conflict_cnt unchanged.
- Macro defined, CNT_W=2, conflict on 5 consecutive edges -> conflict_cnt=3 (saturated); clr_conflict with a conflict on the same edge -> conflict_cnt=1 and the flags stay set.
- RESET_VAL=1010, reset asserted while S=1111 with en=1 -> Q=1010 throughout reset, changed=0000 on release.
